// File: rtl/lcd_spi_stream.sv
// lcd_spi_stream: memory-mapped byte FIFO with a drain engine feeding spi_controller.
//   Bus side : address_in/sel_in/read_in/write_mask_in/write_value_in -> read_value_out, ready_out
//              [3:2]=0 DATA push (dc=1), 1 CMD push (dc=0), 2 STATUS read, 3 CTRL (flush/clear overflow)
//   SPI side : spi_start pulse with spi_data_out/spi_dc_out held until spi_done_in;
//              spi_busy_in blocks a new start.
module lcd_spi_stream #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address_in,
  input  logic        sel_in,
  input  logic        read_in,
  output logic [31:0] read_value_out,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic        ready_out,
  output logic        spi_start,
  output logic [7:0]  spi_data_out,
  output logic        spi_dc_out,
  input  logic        spi_busy_in,
  input  logic        spi_done_in
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_CMD    = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_CTRL   = 2'd3;

  logic [8:0]         mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LEVEL_W-1:0] level;
  logic               overflow;
  logic [1:0]         state;
  logic [1:0]         state_d;
  logic               start_d;
  logic [7:0]         data_d;
  logic               dc_d;

  logic [1:0] reg_sel;
  logic       wr_en;
  logic       push_req;
  logic       push_ok;
  logic       pop;
  logic       flush;
  logic       clr_ovf;
  logic       empty;
  logic       full;
  logic       active;
  logic       unused;

  // Bus decode
  assign reg_sel   = address_in[3:2];
  assign wr_en     = sel_in & (|write_mask_in);
  assign push_req  = wr_en & ((reg_sel == A_DATA) | (reg_sel == A_CMD));
  assign flush     = wr_en & (reg_sel == A_CTRL) & write_value_in[0];
  assign clr_ovf   = wr_en & (reg_sel == A_CTRL) & write_value_in[1];
  assign ready_out = sel_in;
  assign unused    = ^{read_in, address_in[31:4], address_in[1:0], write_value_in[31:8]};

  // FIFO flags; full is taken before this edge's pop, so a push into a full FIFO is dropped
  assign empty   = (level == '0);
  assign full    = (level == LEVEL_W'(DEPTH));
  assign pop     = (state == S_IDLE) & ~empty & ~spi_busy_in;
  assign push_ok = push_req & ~full & ~flush;
  assign active  = (state != S_IDLE) | ~empty;

  // Pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
        level <= level + LEVEL_W'(push_ok) - LEVEL_W'(pop);
      end
      if (clr_ovf)
        overflow <= 1'b0;
      else if (push_req & full)
        overflow <= 1'b1;
    end
  end

  // Storage: {dc, byte}
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {(reg_sel == A_DATA), write_value_in[7:0]};
  end

  // Drain FSM state register and registered SPI outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      spi_start    <= 1'b0;
      spi_data_out <= '0;
      spi_dc_out   <= 1'b0;
    end else begin
      state        <= state_d;
      spi_start    <= start_d;
      spi_data_out <= data_d;
      spi_dc_out   <= dc_d;
    end
  end

  // Drain FSM next state; data/dc hold their value except when a byte is popped
  always_comb begin
    state_d = state;
    start_d = 1'b0;
    data_d  = spi_data_out;
    dc_d    = spi_dc_out;
    case (state)
      S_IDLE: begin
        if (pop) begin
          state_d        = S_START;
          start_d        = 1'b1;
          {dc_d, data_d} = mem[rd_ptr];
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT:  if (spi_done_in) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Combinational read data from current state
  always_comb begin
    read_value_out = '0;
    if (sel_in && (reg_sel == A_STATUS)) begin
      read_value_out[0]            = empty;
      read_value_out[1]            = full;
      read_value_out[2]            = active;
      read_value_out[3]            = overflow;
      read_value_out[8 +: LEVEL_W] = level;
    end
  end

endmodule

// File: tb/tb_lcd_spi_stream.sv
// Testbench for lcd_spi_stream: table-driven register vectors plus directed
// sequences for drain ordering, overflow, push/pop collisions, flush and reset.
module tb_lcd_spi_stream;

  localparam int XFER = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] address_in = '0;
  logic        sel_in = 1'b0;
  logic        read_in = 1'b0;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in = '0;
  logic [31:0] write_value_in = '0;
  logic        ready_out;
  logic        spi_start;
  logic [7:0]  spi_data_out;
  logic        spi_dc_out;
  logic        spi_busy_in;
  logic        spi_done_in = 1'b0;

  logic force_busy = 1'b0;
  logic model_busy = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  assign spi_busy_in = force_busy | model_busy;

  lcd_spi_stream #(.DEPTH(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .address_in     (address_in),
    .sel_in         (sel_in),
    .read_in        (read_in),
    .read_value_out (read_value_out),
    .write_mask_in  (write_mask_in),
    .write_value_in (write_value_in),
    .ready_out      (ready_out),
    .spi_start      (spi_start),
    .spi_data_out   (spi_data_out),
    .spi_dc_out     (spi_dc_out),
    .spi_busy_in    (spi_busy_in),
    .spi_done_in    (spi_done_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // spi_controller model: sampled 1ns after each rising edge
  logic [8:0] got[$];
  int start_cnt = 0;
  int done_cnt  = 0;
  int cnt       = 0;
  int cyc       = 0;
  int last_cyc  = 0;
  bit first     = 1'b1;
  int epoch     = 0;
  int seen_epoch = 0;

  always begin
    @(posedge clk);
    #1;
    cyc++;
    spi_done_in = 1'b0;
    if (!reset_n || (epoch != seen_epoch)) begin
      seen_epoch = epoch;
      got = {};
      start_cnt = 0;
      done_cnt = 0;
      cnt = 0;
      model_busy = 1'b0;
      first = 1'b1;
    end else if (spi_start) begin
      check("start_while_busy", 32'(spi_busy_in), 32'd0);
      check("start_before_done", 32'(done_cnt), 32'(start_cnt));
      if (!first) check("start_gap_ge3", 32'(cyc - last_cyc >= 3), 32'd1);
      got.push_back({spi_dc_out, spi_data_out});
      start_cnt++;
      last_cyc = cyc;
      first = 1'b0;
      model_busy = 1'b1;
      cnt = XFER;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        model_busy = 1'b0;
        spi_done_in = 1'b1;
        done_cnt++;
      end
    end
  end

  task automatic clear_model();
    epoch++;
    @(negedge clk);
  endtask

  // Bus tasks: called at a falling edge, return at the next falling edge
  task automatic bus_wr(input logic [1:0] idx, input logic [31:0] val);
    address_in     = 32'h4000_0010 | (32'(idx) << 2);
    sel_in         = 1'b1;
    read_in        = 1'b0;
    write_mask_in  = 4'hF;
    write_value_in = val;
    @(negedge clk);
    sel_in        = 1'b0;
    write_mask_in = 4'h0;
  endtask

  task automatic bus_rd_chk(input string nm, input logic [1:0] idx, input logic [31:0] exp);
    address_in    = 32'h4000_0010 | (32'(idx) << 2);
    sel_in        = 1'b1;
    read_in       = 1'b1;
    write_mask_in = 4'h0;
    #1;
    check(nm, read_value_out, exp);
    check({nm, "_ready"}, 32'(ready_out), 32'd1);
    @(negedge clk);
    sel_in  = 1'b0;
    read_in = 1'b0;
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 200; i++) begin
      if (done_cnt >= n) break;
      @(negedge clk);
    end
    check("wait_done_budget", 32'(done_cnt >= n), 32'd1);
  endtask

  task automatic wait_start(input int n);
    for (int i = 0; i < 200; i++) begin
      if (start_cnt >= n) break;
      @(negedge clk);
    end
    check("wait_start_budget", 32'(start_cnt >= n), 32'd1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sel_in = 1'b0;
    write_mask_in = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    clear_model();
  endtask

  typedef struct {
    logic [1:0]  idx;
    logic        rd;
    logic [31:0] val;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] idx, input logic rd, input logic [31:0] val,
                     input logic [31:0] exp, input string nm);
    vec_t v;
    v.idx = idx; v.rd = rd; v.val = val; v.exp = exp; v.nm = nm;
    tbl.push_back(v);
  endtask

  initial begin
    // Overflow / register-map table, run with spi_busy_in held high
    for (int i = 0; i < 17; i++) add(2'd0, 1'b0, 32'hFFFF_FFA0 + 32'(i), 32'h0, "push");
    add(2'd2, 1'b1, 32'h0,      32'h0000_100E, "status_full_ovf");
    add(2'd3, 1'b0, 32'h2,      32'h0,         "ctrl_clr_ovf");
    add(2'd2, 1'b1, 32'h0,      32'h0000_1006, "status_ovf_cleared");
    add(2'd0, 1'b1, 32'h0,      32'h0,         "read_data_zero");
    add(2'd1, 1'b1, 32'h0,      32'h0,         "read_cmd_zero");
    add(2'd3, 1'b1, 32'h0,      32'h0,         "read_ctrl_zero");
    add(2'd2, 1'b0, 32'hFFFF,   32'h0,         "write_status");
    add(2'd2, 1'b1, 32'h0,      32'h0000_1006, "status_after_wr");

    #3 reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    clear_model();

    // Reset state
    address_in = 32'h8;
    #1;
    check("rst_spi_start", 32'(spi_start), 32'd0);
    check("rst_spi_data", 32'(spi_data_out), 32'd0);
    check("rst_spi_dc", 32'(spi_dc_out), 32'd0);
    check("unsel_rdata", read_value_out, 32'd0);
    check("unsel_ready", 32'(ready_out), 32'd0);
    @(negedge clk);
    bus_rd_chk("rst_status", 2'd2, 32'h0000_0001);

    // Three bytes drained in order
    bus_wr(2'd1, 32'h0000_002A);
    bus_wr(2'd0, 32'h0000_0011);
    bus_wr(2'd0, 32'h0000_0022);
    wait_done(3);
    repeat (2) @(negedge clk);
    check("t1_count", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      check("t1_byte0", 32'(got[0]), 32'h02A);
      check("t1_byte1", 32'(got[1]), 32'h111);
      check("t1_byte2", 32'(got[2]), 32'h122);
    end
    bus_rd_chk("t1_status", 2'd2, 32'h0000_0001);

    // Table: fill past full with busy held
    clear_model();
    force_busy = 1'b1;
    foreach (tbl[i]) begin
      if (tbl[i].rd) bus_rd_chk(tbl[i].nm, tbl[i].idx, tbl[i].exp);
      else           bus_wr(tbl[i].idx, tbl[i].val);
    end
    check("t2_no_start", 32'(start_cnt), 32'd0);

    // Full FIFO: push collides with FSM pop -> dropped
    force_busy = 1'b0;
    bus_wr(2'd0, 32'h0000_00EE);
    force_busy = 1'b1;
    bus_rd_chk("t4_status", 2'd2, 32'h0000_0F0C);
    wait_done(1);
    @(negedge clk);
    bus_wr(2'd3, 32'h1);
    bus_rd_chk("t4_flush_keeps_ovf", 2'd2, 32'h0000_0009);
    check("t4_count", 32'(got.size()), 32'd1);
    if (got.size() == 1) check("t4_byte", 32'(got[0]), 32'h1A0);
    bus_wr(2'd3, 32'h2);
    bus_rd_chk("t4_ovf_clr", 2'd2, 32'h0000_0001);

    // Three entries: push coincides with pop, pushed byte goes last
    clear_model();
    bus_wr(2'd0, 32'h31);
    bus_wr(2'd0, 32'h32);
    bus_wr(2'd1, 32'h33);
    bus_rd_chk("t3_level3", 2'd2, 32'h0000_0304);
    force_busy = 1'b0;
    bus_wr(2'd0, 32'h55);
    bus_rd_chk("t3_level_kept", 2'd2, 32'h0000_0304);
    wait_done(4);
    repeat (2) @(negedge clk);
    check("t3_count", 32'(got.size()), 32'd4);
    if (got.size() == 4) begin
      check("t3_byte0", 32'(got[0]), 32'h131);
      check("t3_byte1", 32'(got[1]), 32'h132);
      check("t3_byte2", 32'(got[2]), 32'h033);
      check("t3_byte3", 32'(got[3]), 32'h155);
    end
    check("t3_ovf_none", 32'(read_value_out), 32'd0);

    // Flush while in WAIT: in-flight byte completes, nothing else sent
    do_reset();
    force_busy = 1'b1;
    for (int i = 0; i < 5; i++) bus_wr(2'd0, 32'h61 + 32'(i));
    force_busy = 1'b0;
    wait_start(1);
    @(negedge clk);
    bus_wr(2'd3, 32'h1);
    wait_done(1);
    repeat (10) @(negedge clk);
    check("t5_starts", 32'(start_cnt), 32'd1);
    if (got.size() >= 1) check("t5_byte", 32'(got[0]), 32'h161);
    bus_rd_chk("t5_status", 2'd2, 32'h0000_0001);

    // Asynchronous reset mid-transfer
    clear_model();
    force_busy = 1'b1;
    for (int i = 0; i < 5; i++) bus_wr(2'd1, 32'h91 + 32'(i));
    force_busy = 1'b0;
    wait_start(1);
    @(negedge clk);
    check("t6_data_before", 32'(spi_data_out), 32'h91);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_start", 32'(spi_start), 32'd0);
    check("t6_rst_data", 32'(spi_data_out), 32'd0);
    check("t6_rst_dc", 32'(spi_dc_out), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_rd_chk("t6_status", 2'd2, 32'h0000_0001);
    clear_model();
    repeat (10) @(negedge clk);
    check("t6_no_start", 32'(start_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
